// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
package seq_det_pkg;

    // Power-up configuration: the legacy lab-3 "10110" detector, overlapping.
    localparam logic [7:0]  DEF_PATTERN = 8'b0001_0110;
    localparam int unsigned DEF_LEN     = 5;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Width of a length field able to hold 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Out-of-range lengths (0 or above max_len) mean "use the full history".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return ((len == 0) || (len > max_len)) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating count of valid bits.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LW      = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_shift,
    input  logic               i_bit,
    input  logic               i_clear,
    input  logic               i_drop_fill,
    output logic [MAX_LEN-1:0] o_hist,
    output logic [LW-1:0]      o_fill,
    output logic [MAX_LEN-1:0] o_hist_nxt,
    output logic [LW-1:0]      o_fill_nxt
);

    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;

    // Candidate state after accepting i_bit; the top compares against these.
    always_comb begin
        o_hist_nxt = {r_hist[MAX_LEN-2:0], i_bit};
        o_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + LW'(1);
    end

    // History/fill update; a non-overlap match restarts fill but keeps the bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= o_hist_nxt;
            r_fill <= i_drop_fill ? '0 : o_fill_nxt;
        end
    end

    assign o_hist = r_hist;
    assign o_fill = r_fill;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with overlap control and a
// saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int unsigned        DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter logic               DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [MAX_LEN-1:0]               cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]        cfg_len,
    input  logic                             cfg_overlap,
    input  logic                             cnt_clr,
    input  logic                             in_valid,
    input  logic                             in,
    output logic                             out,
    output logic [CNT_W-1:0]                 match_cnt,
    output logic                             cnt_sat
);

    localparam int unsigned   LW          = len_w(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN     = LW'(clamp_len(DEF_LEN, MAX_LEN));

    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_ovl;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_match;
    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist;
    logic [LW-1:0]      w_fill;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LW-1:0]      w_fill_nxt;

    // A config load wins over a data bit presented in the same cycle.
    assign w_accept = in_valid & ~cfg_we;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .i_shift     (w_accept),
        .i_bit       (in),
        .i_clear     (cfg_we),
        .i_drop_fill (w_match & ~r_ovl),
        .o_hist      (w_hist),
        .o_fill      (w_fill),
        .o_hist_nxt  (w_hist_nxt),
        .o_fill_nxt  (w_fill_nxt)
    );

    // Low-len-bit mask and compare against the history including the new bit.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LW'(i) < r_len);
        end
        w_match = w_accept && (w_fill_nxt >= r_len)
                  && (((w_hist_nxt ^ r_pat) & w_mask) == '0);
    end

    // Configuration registers, reloaded on cfg_we with the length clamped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= DEF_PATTERN;
            r_len <= RST_LEN;
            r_ovl <= DEF_OVERLAP;
        end else if (cfg_we) begin
            r_pat <= cfg_pattern;
            r_len <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
            r_ovl <= cfg_overlap;
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    // Saturating match counter; clear beats a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;
    assign cnt_sat   = (r_cnt == '1);

endmodule
